// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned ROW_IDX_W = 2;
  localparam int unsigned COL_IDX_W = 2;
  localparam int unsigned KEY_W     = ROW_IDX_W + COL_IDX_W;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_RELEASE
  } state_t;

  // Index of the lowest row bit that reads 0 (closed); 0 when none is closed.
  function automatic logic [ROW_IDX_W-1:0] lowest_zero(input logic [ROW_W-1:0] row);
    logic [ROW_IDX_W-1:0] idx;
    logic                 found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ROW_W; i++) begin
      if (!row[i] && !found) begin
        idx   = ROW_IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [COL_W-1:0] col_drive(input logic [COL_IDX_W-1:0] idx);
    return ~(COL_W'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Key hand-off between the scanner (master) and its consumer (slave).
interface keypad_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ack;
  logic             overrun;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ack
  );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; idles high.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] i_row,
  output logic [ROW_W-1:0] o_row_s
);

  logic [ROW_W-1:0] r_meta;
  logic [ROW_W-1:0] r_sync;

  // Shift the raw rows through two flops; reset to the idle (all-open) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_row;
      r_sync <= r_meta;
    end
  end

  assign o_row_s = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, one-slot
// key buffer with acknowledge and sticky overrun flag.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] row_in,
  output logic [COL_W-1:0] col_out,
  keypad_if.master         key_bus
);

  localparam int unsigned CNT_MAX   = (SCAN_DIV > DEBOUNCE_CNT + 1) ? SCAN_DIV : DEBOUNCE_CNT + 1;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [ROW_W-1:0]     w_row_s;

  state_t               r_state,     w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
  logic [COL_IDX_W-1:0] r_col,       w_col_nxt;
  logic [ROW_IDX_W-1:0] r_row_idx,   w_row_idx_nxt;
  logic [ROW_W-1:0]     r_pattern,   w_pattern_nxt;
  logic [KEY_W-1:0]     r_key_code,  w_key_code_nxt;
  logic                 r_key_valid, w_key_valid_nxt;
  logic                 r_overrun,   w_overrun_nxt;
  logic [COL_W-1:0]     r_col_out;
  logic [COL_IDX_W-1:0] w_col_inc;

  keypad_row_sync u_row_sync (
    .clk     (clk),
    .rst     (rst),
    .i_row   (row_in),
    .o_row_s (w_row_s)
  );

  assign w_col_inc = r_col + COL_IDX_W'(1);

  // State, shared dwell/debounce counter, column index and key slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_cnt       <= '0;
      r_col       <= '0;
      r_row_idx   <= '0;
      r_pattern   <= '1;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_col_out   <= col_drive('0);
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_col       <= w_col_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_pattern   <= w_pattern_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_overrun   <= w_overrun_nxt;
      // Registered from the next index so col_out moves on the same edge as r_col.
      r_col_out   <= col_drive(w_col_nxt);
    end
  end

  // Next-state logic for the scan FSM and the key slot handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_col_nxt       = r_col;
    w_row_idx_nxt   = r_row_idx;
    w_pattern_nxt   = r_pattern;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = r_key_valid;
    w_overrun_nxt   = r_overrun;

    case (r_state)
      ST_SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_cnt_nxt = '0;
          if (&w_row_s) begin
            w_col_nxt = w_col_inc;
          end else begin
            w_pattern_nxt = w_row_s;
            w_row_idx_nxt = lowest_zero(w_row_s);
            w_state_nxt   = ST_DEBOUNCE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_DEBOUNCE: begin
        if (w_row_s == r_pattern) begin
          if (r_cnt == DEB_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_REPORT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_col_nxt   = w_col_inc;
          w_state_nxt = ST_SCAN;
        end
      end

      ST_REPORT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (&w_row_s) begin
          if (r_cnt == DEB_LAST) begin
            w_cnt_nxt   = '0;
            w_col_nxt   = w_col_inc;
            w_state_nxt = ST_SCAN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
    endcase

    // An ack in the REPORT cycle frees the slot for the new key instead of clearing it.
    if (r_state == ST_REPORT) begin
      if (!r_key_valid || key_bus.key_ack) begin
        w_key_code_nxt  = {r_row_idx, r_col};
        w_key_valid_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (key_bus.key_ack && r_key_valid) begin
      w_key_valid_nxt = 1'b0;
      w_overrun_nxt   = 1'b0;
    end
  end

  assign col_out           = r_col_out;
  assign key_bus.key_code  = r_key_code;
  assign key_bus.key_valid = r_key_valid;
  assign key_bus.overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        force_en;
  logic [3:0]  force_val;

  int unsigned checks;
  int unsigned failures;
  int unsigned rpt_cnt;
  logic [3:0]  sb_q[$];
  logic        prev_valid;
  logic [3:0]  prev_code;

  keypad_if u_if ();

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .key_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
    if (force_en) row_in = force_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a new key in the slot (valid rise or code change) pops one expectation.
  always @(negedge clk) begin
    if (!rst && u_if.key_valid && (!prev_valid || u_if.key_code != prev_code)) begin
      rpt_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_report: got code %0d expected none at %0t", u_if.key_code, $time);
      end else begin
        chk("report_code", u_if.key_code, sb_q.pop_front());
      end
    end
    prev_valid = u_if.key_valid;
    prev_code  = u_if.key_code;
  end

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_report(input string name);
    int unsigned start;
    int unsigned n;
    start = rpt_cnt;
    n = 0;
    while (rpt_cnt == start && n < 400) begin
      step();
      n++;
    end
    chk(name, rpt_cnt - start, 1);
  endtask

  task automatic ack_pulse();
    u_if.key_ack = 1'b1;
    step();
    u_if.key_ack = 1'b0;
  endtask

  typedef struct {
    int unsigned row;
    int unsigned col;
    logic [3:0]  exp_code;
    logic [3:0]  exp_col_held;
    logic [3:0]  exp_col_next;
  } vec_t;

  vec_t       vecs[5];
  logic [3:0] idle_pat[4];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned base;

    vecs[0] = '{2, 1, 4'd9,  4'b1101, 4'b1011};
    vecs[1] = '{0, 3, 4'd3,  4'b0111, 4'b1110};
    vecs[2] = '{3, 0, 4'd12, 4'b1110, 4'b1101};
    vecs[3] = '{1, 2, 4'd6,  4'b1011, 4'b0111};
    vecs[4] = '{3, 3, 4'd15, 4'b0111, 4'b1110};
    idle_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    checks = 0; failures = 0; rpt_cnt = 0;
    prev_valid = 1'b0; prev_code = '0;
    keys = '0; force_en = 1'b0; force_val = 4'b1111;
    u_if.key_ack = 1'b0;
    rst = 1'b1;
    step();
    chk("reset_col_out", col_out, 4'b1110);
    chk("reset_valid", u_if.key_valid, 0);
    chk("reset_code", u_if.key_code, 0);
    chk("reset_overrun", u_if.overrun, 0);
    step();
    rst = 1'b0;

    // Idle scan: column changes every 4 edges after reset release.
    for (int unsigned k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("idle_col_k%0d", k), col_out, idle_pat[(k / 4) % 4]);
    end
    chk("idle_valid", u_if.key_valid, 0);

    // Table: single held key -> one report, column held, 8 clean cycles to release.
    for (int unsigned i = 0; i < 5; i++) begin
      keys = '0;
      keys[vecs[i].row*4 + vecs[i].col] = 1'b1;
      sb_q.push_back(vecs[i].exp_code);
      wait_report($sformatf("vec%0d_report", i));
      base = rpt_cnt;
      step(30);
      chk($sformatf("vec%0d_col_held", i), col_out, vecs[i].exp_col_held);
      chk($sformatf("vec%0d_single_report", i), rpt_cnt - base, 0);
      keys = '0;
      step(9);
      chk($sformatf("vec%0d_col_release9", i), col_out, vecs[i].exp_col_held);
      step();
      chk($sformatf("vec%0d_col_release10", i), col_out, vecs[i].exp_col_next);
      ack_pulse();
      chk($sformatf("vec%0d_ack_valid", i), u_if.key_valid, 0);
      chk($sformatf("vec%0d_overrun", i), u_if.overrun, 0);
      step(3);
    end

    // Overrun: second key while slot full is dropped.
    keys = '0; keys[1*4+1] = 1'b1;
    sb_q.push_back(4'd5);
    wait_report("ovr_first_report");
    keys = '0;
    step(12);
    keys[3*4+2] = 1'b1;
    n = 0;
    while (!u_if.overrun && n < 400) begin step(); n++; end
    chk("ovr_flag", u_if.overrun, 1);
    chk("ovr_code_kept", u_if.key_code, 5);
    chk("ovr_valid", u_if.key_valid, 1);
    keys = '0;
    step(12);
    ack_pulse();
    chk("ovr_ack_valid", u_if.key_valid, 0);
    chk("ovr_ack_overrun", u_if.overrun, 0);

    // Ack in the REPORT cycle of a second key hands the slot to the new key.
    keys = '0; keys[1*4+1] = 1'b1;
    sb_q.push_back(4'd5);
    wait_report("air_first_report");
    keys = '0;
    step(12);
    keys[3*4+2] = 1'b1;
    sb_q.push_back(4'd14);
    n = 0;
    while (dut.r_state != ST_REPORT && n < 400) begin step(); n++; end
    chk("air_reached_report", n < 400, 1);
    ack_pulse();
    chk("air_valid", u_if.key_valid, 1);
    chk("air_code", u_if.key_code, 14);
    chk("air_overrun", u_if.overrun, 0);
    keys = '0;
    step(12);
    ack_pulse();
    chk("air_final_valid", u_if.key_valid, 0);

    // Bounce: row 0 seen low for 3 debounce cycles, then high.
    force_en = 1'b1; force_val = 4'b1110;
    do_reset();
    step(5);
    force_val = 4'b1111;
    step(2);
    chk("bounce_col_held_e7", col_out, 4'b1110);
    step();
    chk("bounce_col_next_e8", col_out, 4'b1101);
    step(3);
    chk("bounce_col_e11", col_out, 4'b1101);
    step();
    chk("bounce_col_e12", col_out, 4'b1011);
    base = rpt_cnt;
    step(40);
    chk("bounce_no_report", rpt_cnt - base, 0);
    chk("bounce_valid", u_if.key_valid, 0);
    force_en = 1'b0;

    // Reset mid-DEBOUNCE with a full slot: outputs clear at once, no late report.
    keys = '0; keys[1*4+1] = 1'b1;
    sb_q.push_back(4'd5);
    wait_report("rst_first_report");
    keys = '0;
    step(12);
    keys[2*4+0] = 1'b1;
    n = 0;
    while (dut.r_state != ST_DEBOUNCE && n < 400) begin step(); n++; end
    chk("rst_reached_debounce", n < 400, 1);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", u_if.key_valid, 0);
    chk("rst_async_code", u_if.key_code, 0);
    chk("rst_async_overrun", u_if.overrun, 0);
    chk("rst_async_col", col_out, 4'b1110);
    keys = '0;
    step(2);
    rst = 1'b0;
    base = rpt_cnt;
    step(60);
    chk("rst_no_report", rpt_cnt - base, 0);
    chk("rst_valid_after", u_if.key_valid, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
